toast_wb_arbiter: RTL and testbench



---
 rtl/toast_pkg.sv | 12 +
 rtl/toast_wb_arbiter_if.sv | 43 ++++
 rtl/toast_wb_fifo.sv | 56 +++++
 rtl/toast_wb_arbiter.sv | 82 ++++++++
 tb/tb_toast_wb_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/toast_pkg.sv
// Shared types and widths for the toast core's writeback-side blocks.
package toast_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } ll_entry_t;

endpackage

// File: rtl/toast_wb_arbiter_if.sv
// Writeback-side bus of the arbiter: pipeline WB request, LL result channel,
// register-file write port and status outputs.
interface toast_wb_arbiter_if
   import toast_pkg::*;
#(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [REG_ADDR_W-1:0] WB_rd_addr_i;
   logic [XLEN-1:0]       WB_rd_wr_data_i;
   logic                  WB_rd_wr_en_i;

   logic                  LL_valid_i;
   logic                  LL_ready_o;
   logic [REG_ADDR_W-1:0] LL_rd_addr_i;
   logic [XLEN-1:0]       LL_data_i;

   logic [REG_ADDR_W-1:0] RF_rd_addr_o;
   logic [XLEN-1:0]       RF_rd_wr_data_o;
   logic                  RF_rd_wr_en_o;

   logic                  stall_req_o;
   logic [CW-1:0]         ll_pending_o;

   // Driver side: WB stage, LL unit, register file and hazard unit together.
   modport master (
      output WB_rd_addr_i, WB_rd_wr_data_i, WB_rd_wr_en_i,
      output LL_valid_i, LL_rd_addr_i, LL_data_i,
      input  LL_ready_o,
      input  RF_rd_addr_o, RF_rd_wr_data_o, RF_rd_wr_en_o,
      input  stall_req_o, ll_pending_o
   );

   modport slave (
      input  WB_rd_addr_i, WB_rd_wr_data_i, WB_rd_wr_en_i,
      input  LL_valid_i, LL_rd_addr_i, LL_data_i,
      output LL_ready_o,
      output RF_rd_addr_o, RF_rd_wr_data_o, RF_rd_wr_en_o,
      output stall_req_o, ll_pending_o
   );

endinterface

// File: rtl/toast_wb_fifo.sv
// DEPTH-entry synchronous FIFO for long-latency results; storage is not reset,
// only the pointers and occupancy are.
module toast_wb_fifo
   import toast_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic      clk_i,
   input  logic      resetn_i,
   input  logic      push_i,
   input  ll_entry_t entry_i,
   input  logic      pop_i,
   output ll_entry_t head_o,
   output logic [CW-1:0] count_o
);

   ll_entry_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= entry_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/toast_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB always wins, buffered LL
// results drain on free cycles, and a starvation counter asks for a WB bubble.
module toast_wb_arbiter
   import toast_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   toast_wb_arbiter_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic          wb_act;
   logic          ll_ready;
   logic          push;
   logic          pop;
   logic          fifo_nempty;
   ll_entry_t     ll_entry;
   ll_entry_t     head;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_q, starve_d;

   // A WB write to x0 is architecturally a no-op, so it does not claim the port.
   assign wb_act      = bus.WB_rd_wr_en_i && (bus.WB_rd_addr_i != '0);
   assign fifo_nempty = (count != '0);
   assign ll_ready    = (count < CW'(DEPTH));
   assign push        = bus.LL_valid_i && ll_ready && (bus.LL_rd_addr_i != '0);
   assign pop         = !wb_act && fifo_nempty;

   assign ll_entry.addr = bus.LL_rd_addr_i;
   assign ll_entry.data = bus.LL_data_i;

   toast_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .push_i   (push),
      .entry_i  (ll_entry),
      .pop_i    (pop),
      .head_o   (head),
      .count_o  (count)
   );

   always_comb begin
      bus.RF_rd_addr_o    = '0;
      bus.RF_rd_wr_data_o = '0;
      bus.RF_rd_wr_en_o   = 1'b0;
      if (wb_act) begin
         bus.RF_rd_addr_o    = bus.WB_rd_addr_i;
         bus.RF_rd_wr_data_o = bus.WB_rd_wr_data_i;
         bus.RF_rd_wr_en_o   = 1'b1;
      end else if (fifo_nempty) begin
         bus.RF_rd_addr_o    = head.addr;
         bus.RF_rd_wr_data_o = head.data;
         bus.RF_rd_wr_en_o   = 1'b1;
      end
   end

   // Saturates so a WB stream that ignores stall_req keeps the request asserted.
   always_comb begin
      starve_d = starve_q;
      if (!fifo_nempty || pop)
         starve_d = '0;
      else if (wb_act && (starve_q != SW'(STARVE_LIMIT)))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) starve_q <= '0;
      else           starve_q <= starve_d;
   end

   assign bus.stall_req_o  = (starve_q == SW'(STARVE_LIMIT));
   assign bus.LL_ready_o   = ll_ready;
   assign bus.ll_pending_o = count;

endmodule

// File: tb/tb_toast_wb_arbiter.sv
// Bench for toast_wb_arbiter: directed vector table, corner sequences, and
// random traffic against a queue-based reference model.
module tb_toast_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   toast_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

   toast_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i    (clk),
      .resetn_i (rstn),
      .bus      (bus.slave)
   );

   typedef struct {
      logic        wb_en;
      logic [4:0]  wb_a;
      logic [31:0] wb_d;
      logic        llv;
      logic [4:0]  ll_a;
      logic [31:0] ll_d;
      logic        e_en;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      logic        e_rdy;
      logic        e_stall;
      logic [1:0]  e_pend;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   vec_t tbl [16];
   ent_t q[$];
   int   starve;

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      bus.WB_rd_wr_en_i   = we;
      bus.WB_rd_addr_i    = wa;
      bus.WB_rd_wr_data_i = wd;
      bus.LL_valid_i      = lv;
      bus.LL_rd_addr_i    = la;
      bus.LL_data_i       = ld;
   endtask

   task automatic check(input string nm, input logic en, input logic [4:0] a,
                        input logic [31:0] d, input logic rdy, input logic st,
                        input logic [1:0] pend);
      n_chk++;
      if (bus.RF_rd_wr_en_o !== en || bus.RF_rd_addr_o !== a || bus.RF_rd_wr_data_o !== d ||
          bus.LL_ready_o !== rdy || bus.stall_req_o !== st || bus.ll_pending_o !== pend) begin
         n_err++;
         $display("FAIL %s: got en=%0b a=%0d d=%h rdy=%0b stall=%0b pend=%0d, want en=%0b a=%0d d=%h rdy=%0b stall=%0b pend=%0d",
                  nm, bus.RF_rd_wr_en_o, bus.RF_rd_addr_o, bus.RF_rd_wr_data_o, bus.LL_ready_o,
                  bus.stall_req_o, bus.ll_pending_o, en, a, d, rdy, st, pend);
      end
   endtask

   task automatic check_bit(input string nm, input logic got, input logic want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0b want %0b", nm, got, want);
      end
   endtask

   task automatic check_addr(input string nm, input logic en, input logic [4:0] a,
                             input logic [31:0] d);
      n_chk++;
      if (bus.RF_rd_wr_en_o !== en || bus.RF_rd_addr_o !== a || bus.RF_rd_wr_data_o !== d) begin
         n_err++;
         $display("FAIL %s: got en=%0b a=%0d d=%h want en=%0b a=%0d d=%h", nm,
                  bus.RF_rd_wr_en_o, bus.RF_rd_addr_o, bus.RF_rd_wr_data_o, en, a, d);
      end
   endtask

   // One clock of the reference model: expected outputs from the queue, then
   // apply the write-port rules to the queue and the wait counter.
   task automatic model_cycle(input string nm);
      logic        act, e_en, popd, acc;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      act  = bus.WB_rd_wr_en_i && bus.WB_rd_addr_i != 0;
      e_en = 0; e_a = 0; e_d = 0;
      if (act) begin
         e_en = 1; e_a = bus.WB_rd_addr_i; e_d = bus.WB_rd_wr_data_i;
      end else if (q.size() != 0) begin
         e_en = 1; e_a = q[0].a; e_d = q[0].d;
      end
      check(nm, e_en, e_a, e_d, q.size() < DEPTH, starve == LIMIT, 2'(q.size()));
      popd = !act && q.size() != 0;
      acc  = bus.LL_valid_i && q.size() < DEPTH;
      if (q.size() == 0 || popd) starve = 0;
      else if (act && starve < LIMIT) starve++;
      if (popd) void'(q.pop_front());
      if (acc && bus.LL_rd_addr_i != 0) q.push_back('{bus.LL_rd_addr_i, bus.LL_data_i});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0};
      tbl[1]  = '{0, 0, 32'h0,    1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0};
      tbl[2]  = '{0, 0, 32'h0,    0, 0, 32'h0,        1, 5, 32'hDEADBEEF, 1, 0, 1};
      tbl[3]  = '{0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0};
      tbl[4]  = '{1, 3, 32'h33,   1, 7, 32'h77,       1, 3, 32'h33,       1, 0, 0};
      tbl[5]  = '{1, 3, 32'h33,   1, 8, 32'h88,       1, 3, 32'h33,       1, 0, 1};
      tbl[6]  = '{1, 3, 32'h33,   1, 9, 32'h99,       1, 3, 32'h33,       0, 0, 2};
      tbl[7]  = '{1, 3, 32'h33,   0, 0, 32'h0,        1, 3, 32'h33,       0, 0, 2};
      tbl[8]  = '{1, 3, 32'h33,   0, 0, 32'h0,        1, 3, 32'h33,       0, 0, 2};
      tbl[9]  = '{1, 3, 32'h33,   0, 0, 32'h0,        1, 3, 32'h33,       0, 1, 2};
      tbl[10] = '{0, 3, 32'h33,   0, 0, 32'h0,        1, 7, 32'h77,       0, 1, 2};
      tbl[11] = '{1, 3, 32'h33,   0, 0, 32'h0,        1, 3, 32'h33,       1, 0, 1};
      tbl[12] = '{0, 0, 32'h0,    0, 0, 32'h0,        1, 8, 32'h88,       1, 0, 1};
      tbl[13] = '{1, 0, 32'h5555, 1, 9, 32'h1234,     0, 0, 32'h0,        1, 0, 0};
      tbl[14] = '{1, 0, 32'h5555, 1, 0, 32'hABCD,     1, 9, 32'h1234,     1, 0, 1};
      tbl[15] = '{0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0};

      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("reset", 0, 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].wb_en, tbl[i].wb_a, tbl[i].wb_d, tbl[i].llv, tbl[i].ll_a, tbl[i].ll_d);
         @(negedge clk);
         check($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_a, tbl[i].e_d,
               tbl[i].e_rdy, tbl[i].e_stall, tbl[i].e_pend);
         tick();
      end

      // Full FIFO: pop and offered result in the same cycle; ready returns a cycle later.
      drive(1, 3, 32'h33, 1, 10, 32'hA); tick();
      drive(1, 3, 32'h33, 1, 11, 32'hB); tick();
      drive(0, 0, 0, 1, 12, 32'hC);
      @(negedge clk);
      check_bit("full_pop_ready", bus.LL_ready_o, 1'b0);
      check_addr("order_x10", 1, 10, 32'hA);
      tick();
      drive(1, 3, 32'h33, 1, 12, 32'hC);
      @(negedge clk);
      check_bit("ready_after_pop", bus.LL_ready_o, 1'b1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk); check_addr("order_x11", 1, 11, 32'hB); tick();
      @(negedge clk); check_addr("order_x12", 1, 12, 32'hC); tick();
      @(negedge clk); check_addr("drained", 0, 0, 0);        tick();

      q.delete();
      starve = 0;
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31) < 4 ? 0 : $urandom_range(1, 31)),
               $urandom, $urandom_range(0, 99) < 45,
               5'($urandom_range(0, 31) < 3 ? 0 : $urandom_range(1, 31)), $urandom);
         @(negedge clk);
         model_cycle($sformatf("rand%0d", i));
         tick();
      end

      // Reset while two results are buffered and the stall request is up.
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      drive(1, 3, 32'h33, 1, 20, 32'h20); tick();
      drive(1, 3, 32'h33, 1, 21, 32'h21); tick();
      drive(1, 3, 32'h33, 0, 0, 0);
      repeat (4) tick();
      @(negedge clk);
      check("pre_reset", 1, 3, 32'h33, 0, 1, 2);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      rstn = 1'b0;
      #1;
      check("async_reset", 0, 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_reset%0d", i), 0, 0, 0, 1, 0, 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
